sid_control_multi: RTL and testbench
====================================

SID_CONTROL_MULTI -- requirements
Module: sid_control_multi

Interface
REQ-001 Parameter NUM_SIDS, default 2: number of emulated SID chips, legal range 1..4.
REQ-002 Parameter TTL_MOS6581, default 10'd7: data bus fade time for 6581, in ms ticks.
REQ-003 Parameter TTL_MOS8580, default 10'd664: data bus fade time for 8580, in ms ticks.
REQ-004 Port clk, input, 1: single system clock; one clock, all logic on posedge clk.
REQ-005 Port res, input, 1: reset, synchronous, active-high; bus_i.res is ignored.
REQ-006 Port tick_ms, input, 1: one-cycle strobe every millisecond.
REQ-007 Port bus_i, input, sid::bus_i_t: addr, data, phi2, r_w_n.
REQ-008 Port cs, input, NUM_SIDS: per-chip select, more than one bit may be set.
REQ-009 Port model, input, NUM_SIDS: per-chip sid::MOS6581/MOS8580.
REQ-010 Port readback_en, input, 1: 1 = write-only registers read back the last written value.
REQ-011 Port mreg, input, NUM_SIDS x sid::misc_reg_t: per-chip POTX/POTY/OSC3/ENV3.
REQ-012 Port voice_req / voice_idx, input, 1 / 4: stream request for voice voice_idx in 0..3*NUM_SIDS-1.
REQ-013 Port voice_valid / voice_o, output, 1 / sid::voice_reg_t: streamed voice registers.
REQ-014 Port filter_req / filter_idx, input, 1 / 2: stream request for chip filter_idx.
REQ-015 Port filter_valid / filter_o, output, 1 / sid::filter_reg_t: streamed filter registers.
REQ-016 Port data_o, output, sid::reg8_t: read data to the host bus.

Function
REQ-017 Each chip SHALL hold 25 bytes of registers at 0x00-0x18: voice v at 0x00+7v (v = 0..2), filter at 0x15.
REQ-018 A write strobe SHALL be ~phi2 & ~r_w_n with any cs bit set, and SHALL be committed once per bus cycle, on the first clk where it is seen.
REQ-019 A write SHALL update the addressed byte in every selected chip; addresses 0x19-0x1F SHALL only update dbus.
REQ-020 Read SHALL be phi2 & r_w_n with cs set; the source chip SHALL be the lowest-index set cs bit.
REQ-021 data_o SHALL be combinational from address (no added latency): 0x19-0x1C from mreg[chip] byte addr-0x19; 0x00-0x18 from the regfile if readback_en, otherwise from dbus value; 0x1D-0x1F from dbus value.
REQ-022 When no read is active, data_o SHALL be the dbus value of the lowest-index set cs bit, or of chip 0 when cs is 0.
REQ-023 Per chip, a read or write SHALL load dbus value with the read or written data and clear age to 0.
REQ-024 Otherwise, age SHALL increment on tick_ms; when age equals the model TTL, value SHALL clear to 0 and age SHALL hold.
REQ-025 A voice_req SHALL produce voice_valid=1 and the voice_o of voice voice_idx (chip = idx/3) exactly one cycle later; filter_req/filter_o SHALL behave the same way.
REQ-026 If a stream read and a write hit the same byte in the same cycle, the stream SHALL return the old value; the new value SHALL be visible from the next request.
REQ-027 An out-of-range voice_idx or filter_idx SHALL return all zeros, with valid still asserted.
REQ-028 Back-to-back requests SHALL be accepted every cycle, giving full throughput.

Reset
REQ-029 While res is high, all registers, dbus values and ages, voice_o, filter_o, voice_valid, filter_valid and the write edge detector SHALL be 0, and writes SHALL be ignored.
REQ-030 Reset during a write strobe SHALL drop the write; a strobe still held after reset releases SHALL NOT be committed.

Structure
REQ-031 Package sid SHALL hold: NUM_SIDS_MAX=4, the register base addresses (voice, filter, misc), and dbus_t (value, age).
REQ-032 Sub-module sid_dbus_fade (one chip's value/age/TTL logic) SHALL be instantiated NUM_SIDS times.

Verification
REQ-033 Write 0x5A to 0x0E with cs=01, then voice_req with idx 2 -> voice_o freq low byte = 0x5A one cycle later; idx 5 -> 0.
REQ-034 Write with cs=11 to 0x17 -> filter_o identical for filter_idx 0 and 1.
REQ-035 Write 0x33 to 0x00, readback_en=0, read 0x00 -> data_o=0x33 (dbus); after 7 ticks with model 6581 -> 0x00; with model 8580, still 0x33 after 663 ticks and 0x00 after 664.
REQ-036 readback_en=1, read 0x00 after fade -> 0x33; read 0x1B -> mreg OSC3.
REQ-037 A write strobe held 5 cycles -> exactly one commit; a stream read in the same cycle as the write returns the old byte.
REQ-038 Assert res mid-write -> all outputs 0; after release, the held strobe causes no commit.

Source files
------------

// File: rtl/sid_control_multi_pkg.sv
// rtl/sid_control_multi_pkg.sv - shared types and register map for the multi-SID register front end
package sid;

  localparam int         NUM_SIDS_MAX  = 4;
  localparam int         REGS_PER_CHIP = 25;
  localparam int         TTL_W         = 10;
  localparam logic [4:0] VOICE_BASE    = 5'h00;
  localparam logic [4:0] VOICE_STRIDE  = 5'd7;
  localparam logic [4:0] FILTER_BASE   = 5'h15;
  localparam logic [4:0] MISC_BASE     = 5'h19;
  localparam logic [4:0] MISC_LAST     = 5'h1C;
  localparam logic [4:0] REG_LAST      = 5'h18;

  typedef logic [7:0] reg8_t;

  typedef enum logic {
    MOS6581 = 1'b0,
    MOS8580 = 1'b1
  } model_t;

  typedef struct packed {
    logic       res;
    logic       phi2;
    logic       r_w_n;
    logic [4:0] addr;
    reg8_t      data;
  } bus_i_t;

  typedef struct packed {
    reg8_t env3;
    reg8_t osc3;
    reg8_t poty;
    reg8_t potx;
  } misc_reg_t;

  typedef struct packed {
    reg8_t freq_lo;
    reg8_t freq_hi;
    reg8_t pw_lo;
    reg8_t pw_hi;
    reg8_t control;
    reg8_t attack_decay;
    reg8_t sustain_release;
  } voice_reg_t;

  typedef struct packed {
    reg8_t fc_lo;
    reg8_t fc_hi;
    reg8_t res_filt;
    reg8_t mode_vol;
  } filter_reg_t;

  typedef struct packed {
    reg8_t            value;
    logic [TTL_W-1:0] age;
  } dbus_t;

  // sel is the byte offset from MISC_BASE: POTX, POTY, OSC3, ENV3
  function automatic reg8_t misc_byte(input misc_reg_t m, input logic [1:0] sel);
    reg8_t b;
    case (sel)
      2'd0:    b = m.potx;
      2'd1:    b = m.poty;
      2'd2:    b = m.osc3;
      default: b = m.env3;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sid_control_multi_if.sv
// rtl/sid_control_multi_if.sv - voice/filter register stream request and response bundle
interface sid_control_multi_if;
  import sid::*;

  logic        voice_req;
  logic [3:0]  voice_idx;
  logic        voice_valid;
  voice_reg_t  voice_o;

  logic        filter_req;
  logic [1:0]  filter_idx;
  logic        filter_valid;
  filter_reg_t filter_o;

  modport master (
    output voice_req, voice_idx, filter_req, filter_idx,
    input  voice_valid, voice_o, filter_valid, filter_o
  );

  modport slave (
    input  voice_req, voice_idx, filter_req, filter_idx,
    output voice_valid, voice_o, filter_valid, filter_o
  );

endinterface

// File: rtl/sid_dbus_fade.sv
// rtl/sid_dbus_fade.sv - one chip's floating data bus: last value, age in ms, fade to zero at model TTL
module sid_dbus_fade
  import sid::*;
#(
  parameter logic [9:0] TTL_MOS6581 = 10'd7,
  parameter logic [9:0] TTL_MOS8580 = 10'd664
) (
  input  logic  clk,
  input  logic  res,
  input  logic  tick_ms,
  input  logic  model_i,
  input  logic  load_i,
  input  reg8_t load_data_i,
  output dbus_t dbus_o
);

  dbus_t            dbus_q, dbus_d;
  logic [TTL_W-1:0] ttl;

  always_comb begin
    ttl    = (model_t'(model_i) == MOS8580) ? TTL_MOS8580 : TTL_MOS6581;
    dbus_d = dbus_q;
    if (load_i) begin
      dbus_d.value = load_data_i;
      dbus_d.age   = '0;
    end else if (dbus_q.age >= ttl) begin
      // >= keeps the age pinned if the model is switched to a shorter TTL
      dbus_d.value = '0;
    end else if (tick_ms) begin
      dbus_d.age = dbus_q.age + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      dbus_q <= '0;
    end else begin
      dbus_q <= dbus_d;
    end
  end

  assign dbus_o = dbus_q;

endmodule

// File: rtl/sid_control_multi.sv
// rtl/sid_control_multi.sv - register file, host bus decode and voice/filter streaming for 1..4 SID chips
module sid_control_multi
  import sid::*;
#(
  parameter int         NUM_SIDS    = 2,
  parameter logic [9:0] TTL_MOS6581 = 10'd7,
  parameter logic [9:0] TTL_MOS8580 = 10'd664
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     tick_ms,
  input  bus_i_t                   bus_i,
  input  logic [NUM_SIDS-1:0]      cs,
  input  logic [NUM_SIDS-1:0]      model,
  input  logic                     readback_en,
  input  misc_reg_t [NUM_SIDS-1:0] mreg,
  sid_control_multi_if.slave       strm,
  output reg8_t                    data_o
);

  reg8_t       regs_q [NUM_SIDS][REGS_PER_CHIP];
  dbus_t       dbus [NUM_SIDS];
  logic [NUM_SIDS-1:0] dbus_load;
  reg8_t       dbus_load_data [NUM_SIDS];

  logic        wr_strobe, wr_commit, rd_act;
  logic        addr_is_reg, addr_is_misc;
  logic        wr_seen_q, wr_hold_q;
  int          src;
  reg8_t       src_dbus, src_reg, src_misc, rd_data;

  voice_reg_t  voice_d, voice_q;
  filter_reg_t filter_d, filter_q;
  logic        voice_valid_q, filter_valid_q;
  logic [3:0]  v_chip, v_num;
  logic [4:0]  v_base;

  logic        unused_bus_res;
  assign unused_bus_res = bus_i.res;

  assign wr_strobe    = ~bus_i.phi2 & ~bus_i.r_w_n & (|cs);
  assign rd_act       = bus_i.phi2 & bus_i.r_w_n & (|cs);
  assign wr_commit    = wr_strobe & ~wr_seen_q & ~wr_hold_q & ~res;
  assign addr_is_reg  = bus_i.addr <= REG_LAST;
  assign addr_is_misc = (bus_i.addr >= MISC_BASE) && (bus_i.addr <= MISC_LAST);

  // wr_hold_q remembers a strobe that straddled reset so it is never committed
  always_ff @(posedge clk) begin
    if (res) begin
      wr_seen_q <= 1'b0;
      wr_hold_q <= wr_strobe;
    end else begin
      wr_seen_q <= wr_strobe;
      wr_hold_q <= wr_hold_q & wr_strobe;
    end
  end

  always_comb begin
    src = 0;
    for (int i = NUM_SIDS - 1; i >= 0; i--) begin
      if (cs[i]) src = i;
    end
  end

  always_comb begin
    src_dbus = '0;
    src_reg  = '0;
    src_misc = '0;
    for (int i = 0; i < NUM_SIDS; i++) begin
      if (i == src) begin
        src_dbus = dbus[i].value;
        src_reg  = addr_is_reg ? regs_q[i][bus_i.addr] : '0;
        src_misc = misc_byte(mreg[i], 2'(bus_i.addr - MISC_BASE));
      end
    end
    if (addr_is_misc) begin
      rd_data = src_misc;
    end else if (addr_is_reg && readback_en) begin
      rd_data = src_reg;
    end else begin
      rd_data = src_dbus;
    end
    data_o = rd_act ? rd_data : src_dbus;
  end

  always_comb begin
    dbus_load = '0;
    for (int i = 0; i < NUM_SIDS; i++) begin
      dbus_load[i]      = (wr_commit & cs[i]) | (rd_act & (i == src));
      dbus_load_data[i] = wr_commit ? bus_i.data : rd_data;
    end
  end

  for (genvar g = 0; g < NUM_SIDS; g++) begin : g_fade
    sid_dbus_fade #(
      .TTL_MOS6581 (TTL_MOS6581),
      .TTL_MOS8580 (TTL_MOS8580)
    ) u_fade (
      .clk         (clk),
      .res         (res),
      .tick_ms     (tick_ms),
      .model_i     (model[g]),
      .load_i      (dbus_load[g]),
      .load_data_i (dbus_load_data[g]),
      .dbus_o      (dbus[g])
    );
  end

  // Indices past the last chip match no loop iteration and stay zero
  always_comb begin
    voice_d  = '0;
    filter_d = '0;
    v_chip   = strm.voice_idx / 4'd3;
    v_num    = strm.voice_idx % 4'd3;
    v_base   = VOICE_BASE + 5'(v_num) * VOICE_STRIDE;
    for (int i = 0; i < NUM_SIDS; i++) begin
      if (v_chip == 4'(i)) begin
        voice_d.freq_lo         = regs_q[i][v_base];
        voice_d.freq_hi         = regs_q[i][v_base + 5'd1];
        voice_d.pw_lo           = regs_q[i][v_base + 5'd2];
        voice_d.pw_hi           = regs_q[i][v_base + 5'd3];
        voice_d.control         = regs_q[i][v_base + 5'd4];
        voice_d.attack_decay    = regs_q[i][v_base + 5'd5];
        voice_d.sustain_release = regs_q[i][v_base + 5'd6];
      end
      if (strm.filter_idx == 2'(i)) begin
        filter_d.fc_lo    = regs_q[i][FILTER_BASE];
        filter_d.fc_hi    = regs_q[i][FILTER_BASE + 5'd1];
        filter_d.res_filt = regs_q[i][FILTER_BASE + 5'd2];
        filter_d.mode_vol = regs_q[i][FILTER_BASE + 5'd3];
      end
    end
  end

  // Streams sample regs_q before this edge's write lands, so a colliding write is seen next time
  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < NUM_SIDS; i++) begin
        for (int j = 0; j < REGS_PER_CHIP; j++) begin
          regs_q[i][j] <= '0;
        end
      end
      voice_valid_q  <= 1'b0;
      voice_q        <= '0;
      filter_valid_q <= 1'b0;
      filter_q       <= '0;
    end else begin
      for (int i = 0; i < NUM_SIDS; i++) begin
        if (wr_commit && cs[i] && addr_is_reg) regs_q[i][bus_i.addr] <= bus_i.data;
      end
      voice_valid_q  <= strm.voice_req;
      filter_valid_q <= strm.filter_req;
      if (strm.voice_req) voice_q <= voice_d;
      if (strm.filter_req) filter_q <= filter_d;
    end
  end

  assign strm.voice_valid  = voice_valid_q;
  assign strm.voice_o      = voice_q;
  assign strm.filter_valid = filter_valid_q;
  assign strm.filter_o     = filter_q;

endmodule

// File: tb/tb_sid_control_multi.sv
// tb/tb_sid_control_multi.sv - directed vectors for the multi-SID register front end
module tb_sid_control_multi;
  import sid::*;

  logic             clk = 1'b0;
  logic             res, tick_ms, readback_en;
  bus_i_t           bus_s;
  logic [1:0]       cs, model;
  misc_reg_t [1:0]  mreg;
  reg8_t            data_o;
  filter_reg_t      fexp;
  int               n_vec = 0;
  int               n_err = 0;

  sid_control_multi_if strm ();

  sid_control_multi #(
    .NUM_SIDS    (2),
    .TTL_MOS6581 (10'd7),
    .TTL_MOS8580 (10'd664)
  ) dut (
    .clk         (clk),
    .res         (res),
    .tick_ms     (tick_ms),
    .bus_i       (bus_s),
    .cs          (cs),
    .model       (model),
    .readback_en (readback_en),
    .mreg        (mreg),
    .strm        (strm),
    .data_o      (data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus_s.phi2  = 1'b0;
    bus_s.r_w_n = 1'b1;
    cs          = 2'b00;
  endtask

  task automatic wr(input logic [4:0] a, input reg8_t d, input logic [1:0] c);
    bus_s.phi2  = 1'b0;
    bus_s.r_w_n = 1'b0;
    bus_s.addr  = a;
    bus_s.data  = d;
    cs          = c;
    step(1);
    bus_idle();
    step(1);
  endtask

  task automatic rd(input logic [4:0] a, input logic [1:0] c, input string tag, input reg8_t exp);
    bus_s.phi2  = 1'b1;
    bus_s.r_w_n = 1'b1;
    bus_s.addr  = a;
    cs          = c;
    @(negedge clk);
    check(tag, 64'(data_o), 64'(exp));
    step(1);
    bus_idle();
  endtask

  task automatic tick();
    tick_ms = 1'b1;
    step(1);
    tick_ms = 1'b0;
    step(1);
  endtask

  task automatic idle_chk(input string tag, input reg8_t exp);
    @(negedge clk);
    check(tag, 64'(data_o), 64'(exp));
    step(1);
  endtask

  initial begin
    res = 1'b1; tick_ms = 1'b0; readback_en = 1'b0; model = 2'b00;
    bus_s = '0;
    bus_idle();
    mreg[0].potx = 8'h11; mreg[0].poty = 8'h22; mreg[0].osc3 = 8'hC3; mreg[0].env3 = 8'h44;
    mreg[1].potx = 8'h91; mreg[1].poty = 8'h92; mreg[1].osc3 = 8'h5C; mreg[1].env3 = 8'h94;
    strm.voice_req = 1'b1; strm.voice_idx = 4'd0;
    strm.filter_req = 1'b1; strm.filter_idx = 2'd0;

    step(3);
    @(negedge clk);
    check("rst_data_o", 64'(data_o), 64'h0);
    check("rst_voice_valid", 64'(strm.voice_valid), 64'h0);
    check("rst_filter_valid", 64'(strm.filter_valid), 64'h0);
    check("rst_voice_o", 64'(strm.voice_o), 64'h0);
    check("rst_filter_o", 64'(strm.filter_o), 64'h0);
    step(1);
    res = 1'b0; strm.voice_req = 1'b0; strm.filter_req = 1'b0;
    step(2);

    // voice stream, chip 0 voice 2 freq_lo at 0x0E
    wr(5'h0E, 8'h5A, 2'b01);
    strm.voice_req = 1'b1; strm.voice_idx = 4'd2;
    step(1); strm.voice_idx = 4'd5;
    @(negedge clk);
    check("v2_valid", 64'(strm.voice_valid), 64'h1);
    check("v2_freq_lo", 64'(strm.voice_o.freq_lo), 64'h5A);
    step(1); strm.voice_idx = 4'd6;
    @(negedge clk);
    check("v5_zero", 64'(strm.voice_o), 64'h0);
    step(1); strm.voice_req = 1'b0;
    @(negedge clk);
    check("v6_oor_valid", 64'(strm.voice_valid), 64'h1);
    check("v6_oor_zero", 64'(strm.voice_o), 64'h0);
    step(1);
    @(negedge clk);
    check("v_idle_valid", 64'(strm.voice_valid), 64'h0);
    step(1);

    // broadcast write to both chips' res_filt
    wr(5'h17, 8'hA7, 2'b11);
    fexp = '0; fexp.res_filt = 8'hA7;
    strm.filter_req = 1'b1; strm.filter_idx = 2'd0;
    step(1); strm.filter_idx = 2'd1;
    @(negedge clk);
    check("f0", 64'(strm.filter_o), 64'(fexp));
    step(1); strm.filter_idx = 2'd2;
    @(negedge clk);
    check("f1", 64'(strm.filter_o), 64'(fexp));
    step(1); strm.filter_req = 1'b0;
    @(negedge clk);
    check("f2_oor_valid", 64'(strm.filter_valid), 64'h1);
    check("f2_oor_zero", 64'(strm.filter_o), 64'h0);
    step(1);

    // strobe held five edges, data changed after first; stream collides with commit
    bus_s.phi2 = 1'b0; bus_s.r_w_n = 1'b0; bus_s.addr = 5'h0E; bus_s.data = 8'hC4; cs = 2'b01;
    strm.voice_req = 1'b1; strm.voice_idx = 4'd2;
    step(1); bus_s.data = 8'h99;
    @(negedge clk);
    check("same_cycle_old", 64'(strm.voice_o.freq_lo), 64'h5A);
    step(1); strm.voice_req = 1'b0;
    @(negedge clk);
    check("next_req_new", 64'(strm.voice_o.freq_lo), 64'hC4);
    step(3);
    bus_idle();
    step(1);
    strm.voice_req = 1'b1;
    step(1); strm.voice_req = 1'b0;
    @(negedge clk);
    check("hold_one_commit", 64'(strm.voice_o.freq_lo), 64'hC4);
    check("wr_dbus_idle", 64'(data_o), 64'hC4);
    step(1);

    // 6581 fade and read sources
    wr(5'h00, 8'h33, 2'b01);
    rd(5'h00, 2'b01, "rd_dbus", 8'h33);
    repeat (6) tick();
    idle_chk("fade6581_6t", 8'h33);
    tick();
    idle_chk("fade6581_7t", 8'h00);
    rd(5'h00, 2'b01, "rd_faded", 8'h00);
    readback_en = 1'b1;
    rd(5'h00, 2'b01, "rd_readback", 8'h33);
    rd(5'h1B, 2'b01, "rd_osc3_c0", 8'hC3);
    rd(5'h19, 2'b01, "rd_potx_c0", 8'h11);
    rd(5'h1B, 2'b10, "rd_osc3_c1", 8'h5C);
    rd(5'h1C, 2'b11, "rd_lowest_cs", 8'h44);
    rd(5'h1D, 2'b10, "rd_1d_dbus_c1", 8'h5C);
    rd(5'h1F, 2'b01, "rd_1f_dbus_c0", 8'h44);

    // 8580 fade
    readback_en = 1'b0; model = 2'b01;
    wr(5'h00, 8'h6E, 2'b01);
    repeat (663) tick();
    idle_chk("fade8580_663t", 8'h6E);
    tick();
    idle_chk("fade8580_664t", 8'h00);

    // reset asserted together with a write strobe that outlives it
    readback_en = 1'b1; model = 2'b00;
    bus_s.phi2 = 1'b0; bus_s.r_w_n = 1'b0; bus_s.addr = 5'h01; bus_s.data = 8'h77; cs = 2'b01;
    res = 1'b1; strm.voice_req = 1'b1; strm.voice_idx = 4'd2; strm.filter_req = 1'b1;
    step(2);
    @(negedge clk);
    check("rst2_data_o", 64'(data_o), 64'h0);
    check("rst2_voice_valid", 64'(strm.voice_valid), 64'h0);
    check("rst2_voice_o", 64'(strm.voice_o), 64'h0);
    check("rst2_filter_valid", 64'(strm.filter_valid), 64'h0);
    step(1);
    res = 1'b0; strm.voice_req = 1'b0; strm.filter_req = 1'b0;
    step(3);
    bus_idle();
    step(1);
    rd(5'h01, 2'b01, "no_commit_after_rst", 8'h00);
    rd(5'h0E, 2'b01, "rst_cleared_0e", 8'h00);
    wr(5'h01, 8'h77, 2'b01);
    rd(5'h01, 2'b01, "post_rst_write", 8'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
